// File: rtl/cache_rd_arbiter_if.sv
// cache_rd_arbiter_if: ICache/DCache miss-read ports plus AXI read address/data channels
interface cache_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              i_rd_req, d_rd_req;
  logic [2:0]        i_rd_type, d_rd_type;
  logic [ADDR_W-1:0] i_rd_addr, d_rd_addr;
  logic              i_rd_rdy, d_rd_rdy;
  logic              i_ret_valid, d_ret_valid;
  logic              i_ret_last, d_ret_last;
  logic [DATA_W-1:0] i_ret_data, d_ret_data;
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid, arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast, rvalid, rready;
  modport master (
    input  i_rd_req, d_rd_req, i_rd_type, d_rd_type, i_rd_addr, d_rd_addr,
    output i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
    output i_ret_data, d_ret_data,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );
  modport slave (
    output i_rd_req, d_rd_req, i_rd_type, d_rd_type, i_rd_addr, d_rd_addr,
    input  i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last,
    input  i_ret_data, d_ret_data,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cache_rd_arbiter.sv
// cache_rd_arbiter: I/D cache miss-read arbiter onto one AXI read port; define CACHE_RD_ARB_RR_EN for round-robin
module cache_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  input logic                flush,
  cache_rd_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, AR, R} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic long_q, owner_d, cancel;
  logic grant_i, grant_d, hit, is_ar;
`ifdef CACHE_RD_ARB_RR_EN
  logic last_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) last_d <= 1'b0;
    else if (grant_i || grant_d) last_d <= grant_d;
  assign grant_d = state == IDLE && !reset && bus.d_rd_req && (!bus.i_rd_req || !last_d);
`else
  assign grant_d = state == IDLE && !reset && bus.d_rd_req;
`endif
  assign grant_i = state == IDLE && !reset && bus.i_rd_req && !grant_d;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? ((grant_i || grant_d) ? AR : IDLE) :
               state == AR   ? (bus.arready ? R : AR) :
               (bus.rvalid && bus.rlast) ? IDLE : R;
  end
  // an ICache flush only mutes delivery; the AXI burst still has to drain
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr_q  <= '0;
      long_q  <= 1'b0;
      owner_d <= 1'b0;
      cancel  <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        addr_q  <= grant_d ? bus.d_rd_addr : bus.i_rd_addr;
        long_q  <= (grant_d ? bus.d_rd_type : bus.i_rd_type) == 3'b100;
        owner_d <= grant_d;
      end
      cancel <= state_nx != IDLE && (cancel || (flush && !owner_d && state != IDLE));
    end
  always_comb begin
    is_ar           = state == AR;
    hit             = state == R && bus.rvalid && bus.rid == {3'b000, owner_d};
    bus.arvalid     = is_ar;
    bus.araddr      = is_ar ? addr_q : '0;
    bus.arid        = {3'b000, is_ar && owner_d};
    bus.arlen       = (is_ar && long_q) ? 8'd3 : 8'd0;
    bus.arsize      = is_ar ? 3'd2 : 3'd0;
    bus.rready      = state == R;
    bus.i_rd_rdy    = grant_i;
    bus.d_rd_rdy    = grant_d;
    bus.d_ret_valid = hit && owner_d;
    bus.i_ret_valid = hit && !owner_d && !cancel && !flush;
    bus.d_ret_last  = bus.d_ret_valid && bus.rlast;
    bus.i_ret_last  = bus.i_ret_valid && bus.rlast;
    bus.d_ret_data  = bus.d_ret_valid ? bus.rdata : {DATA_W{1'b0}};
    bus.i_ret_data  = bus.i_ret_valid ? bus.rdata : {DATA_W{1'b0}};
  end
endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb_cache_rd_arbiter: directed scenarios plus random traffic against a transaction-level reference model
module tb_cache_rd_arbiter;
`ifdef CACHE_RD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, reset, flush;
  cache_rd_arbiter_if bus ();
  cache_rd_arbiter dut (.clk(clk), .reset(reset), .flush(flush), .bus(bus.master));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  bit m_busy, m_ar, m_own_d, m_long, m_cancel, m_last_d;
  logic [31:0] m_addr;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); #1; endtask
  // model: one outstanding transaction record, address phase then data phase
  always @(negedge clk) begin
    logic e_gd, e_gi, e_ar, e_r, e_dv, e_iv;
    e_gd = !reset && !m_busy && bus.d_rd_req && (!RR || !bus.i_rd_req || !m_last_d);
    e_gi = !reset && !m_busy && bus.i_rd_req && !e_gd;
    e_ar = !reset && m_busy && !m_ar;
    e_r  = !reset && m_busy && m_ar;
    e_dv = e_r && bus.rvalid && m_own_d && bus.rid == 4'd1;
    e_iv = e_r && bus.rvalid && !m_own_d && bus.rid == 4'd0 && !m_cancel && !flush;
    chk("m_i_rd_rdy", bus.i_rd_rdy, e_gi);
    chk("m_d_rd_rdy", bus.d_rd_rdy, e_gd);
    chk("m_arvalid", bus.arvalid, e_ar);
    chk("m_rready", bus.rready, e_r);
    chk("m_i_ret_valid", bus.i_ret_valid, e_iv);
    chk("m_d_ret_valid", bus.d_ret_valid, e_dv);
    if (reset || e_ar) begin
      chk("m_araddr", bus.araddr, e_ar ? m_addr : 32'd0);
      chk("m_arid", bus.arid, e_ar ? {3'd0, m_own_d} : 4'd0);
      chk("m_arlen", bus.arlen, (e_ar && m_long) ? 8'd3 : 8'd0);
      chk("m_arsize", bus.arsize, e_ar ? 3'd2 : 3'd0);
    end
    if (reset || e_iv) begin
      chk("m_i_ret_data", bus.i_ret_data, e_iv ? bus.rdata : 32'd0);
      chk("m_i_ret_last", bus.i_ret_last, e_iv && bus.rlast);
    end
    if (reset || e_dv) begin
      chk("m_d_ret_data", bus.d_ret_data, e_dv ? bus.rdata : 32'd0);
      chk("m_d_ret_last", bus.d_ret_last, e_dv && bus.rlast);
    end
    if (reset) begin
      m_busy = 0; m_ar = 0; m_cancel = 0; m_last_d = 0;
    end else if (!m_busy) begin
      if (e_gd || e_gi) begin
        m_busy = 1; m_ar = 0; m_cancel = 0; m_own_d = e_gd; m_last_d = e_gd;
        m_addr = e_gd ? bus.d_rd_addr : bus.i_rd_addr;
        m_long = (e_gd ? bus.d_rd_type : bus.i_rd_type) == 3'b100;
      end
    end else begin
      if (flush && !m_own_d) m_cancel = 1;
      if (!m_ar) begin
        if (bus.arready) m_ar = 1;
      end else if (bus.rvalid && bus.rlast) begin
        m_busy = 0; m_cancel = 0;
      end
    end
  end
  task automatic serve(input bit own_d, input int beats);
    bus.arready = 1; nxt(); bus.arready = 0;
    for (int b = 0; b < beats; b++) begin
      bus.rvalid = 1; bus.rid = {3'd0, own_d}; bus.rdata = $urandom; bus.rlast = b == beats - 1;
      nxt();
    end
    bus.rvalid = 0; bus.rlast = 0;
  endtask
  task automatic line_req_i(input logic [31:0] a);
    bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = a;
    nxt(); bus.i_rd_req = 0; bus.arready = 1;
    nxt(); bus.arready = 0;
  endtask
  initial begin
    bit got_d;
    reset = 1; flush = 0;
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.i_rd_type = 0; bus.d_rd_type = 0;
    bus.i_rd_addr = 0; bus.d_rd_addr = 0; bus.arready = 1;
    bus.rid = 0; bus.rdata = 32'hdead; bus.rlast = 1; bus.rvalid = 1;
    repeat (2) nxt();
    mid();
    chk("rst_rdy", {bus.i_rd_rdy, bus.d_rd_rdy}, 0);
    chk("rst_axi", {bus.arvalid, bus.rready, bus.arlen, bus.arsize, bus.arid}, 0);
    nxt();
    bus.i_rd_req = 0; bus.d_rd_req = 0; bus.arready = 0; bus.rvalid = 0; bus.rlast = 0; reset = 0;
    nxt();
    // ICache line fill
    bus.i_rd_req = 1; bus.i_rd_type = 3'b100; bus.i_rd_addr = 32'h1fc00000;
    mid(); chk("line_i_rdy", bus.i_rd_rdy, 1); chk("line_d_rdy", bus.d_rd_rdy, 0);
    nxt(); bus.i_rd_req = 0; bus.arready = 1;
    mid();
    chk("line_arlen", bus.arlen, 3); chk("line_arid", bus.arid, 0);
    chk("line_araddr", bus.araddr, 32'h1fc00000); chk("line_arsize", bus.arsize, 2);
    nxt(); bus.arready = 0;
    for (int b = 0; b < 4; b++) begin
      bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'ha000 + b; bus.rlast = b == 3;
      mid();
      chk($sformatf("line_iv%0d", b), bus.i_ret_valid, 1);
      chk($sformatf("line_data%0d", b), bus.i_ret_data, 32'ha000 + b);
      chk($sformatf("line_last%0d", b), bus.i_ret_last, b == 3);
      nxt();
    end
    bus.rvalid = 0; bus.rlast = 0;
    mid(); chk("line_idle", {bus.arvalid, bus.rready}, 0);
    nxt();
    // simultaneous requests
    bus.i_rd_req = 1; bus.d_rd_req = 1; bus.i_rd_type = 0; bus.d_rd_type = 0;
    bus.d_rd_addr = 32'h00001004; bus.i_rd_addr = 32'h00002000;
    mid(); chk("both_d_rdy", bus.d_rd_rdy, 1); chk("both_i_rdy", bus.i_rd_rdy, 0);
    nxt(); bus.d_rd_req = 0; bus.arready = 1;
    mid();
    chk("both_arlen", bus.arlen, 0); chk("both_arid", bus.arid, 1);
    chk("both_araddr", bus.araddr, 32'h1004); chk("both_ar_irdy", bus.i_rd_rdy, 0);
    nxt(); bus.arready = 0; bus.rvalid = 1; bus.rid = 1; bus.rlast = 1; bus.rdata = 32'h55;
    mid();
    chk("both_dv", bus.d_ret_valid, 1); chk("both_ddata", bus.d_ret_data, 32'h55);
    chk("both_dlast", bus.d_ret_last, 1); chk("both_iv", bus.i_ret_valid, 0);
    nxt(); bus.rvalid = 0; bus.rlast = 0;
    mid(); chk("both_i_next", bus.i_rd_rdy, 1);
    nxt(); bus.i_rd_req = 0;
    serve(0, 1);
    for (int k = 0; k < 4; k++) begin
      bus.i_rd_req = 1; bus.d_rd_req = 1;
      mid(); got_d = bus.d_rd_rdy;
      chk($sformatf("contend%0d_d", k), got_d, !RR || k % 2 == 0);
      nxt(); bus.i_rd_req = 0; bus.d_rd_req = 0;
      serve(got_d, 1);
    end
    // address-channel stall
    bus.d_rd_req = 1; bus.d_rd_addr = 32'h3000; bus.d_rd_type = 3'b001;
    nxt(); bus.d_rd_req = 0;
    for (int s = 0; s < 5; s++) begin
      mid();
      chk($sformatf("stall%0d_arvalid", s), bus.arvalid, 1);
      chk($sformatf("stall%0d_araddr", s), bus.araddr, 32'h3000);
      chk($sformatf("stall%0d_arlen", s), bus.arlen, 0);
      chk($sformatf("stall%0d_rready", s), bus.rready, 0);
      nxt();
    end
    serve(1, 1);
    // flush during ICache burst
    line_req_i(32'h1fc00040);
    bus.rvalid = 1; bus.rid = 0; bus.rlast = 0; bus.rdata = 32'h11;
    mid(); chk("fl_beat1_iv", bus.i_ret_valid, 1);
    nxt(); flush = 1;
    mid(); chk("fl_beat2_iv", bus.i_ret_valid, 0); chk("fl_beat2_rready", bus.rready, 1);
    nxt(); flush = 0;
    for (int b = 3; b <= 4; b++) begin
      bus.rlast = b == 4;
      mid();
      chk($sformatf("fl_beat%0d_iv", b), bus.i_ret_valid, 0);
      chk($sformatf("fl_beat%0d_rready", b), bus.rready, 1);
      nxt();
    end
    bus.rvalid = 0; bus.rlast = 0;
    bus.i_rd_req = 1; bus.i_rd_type = 0; bus.i_rd_addr = 32'h44; flush = 1;
    mid(); chk("fl_idle_grant", bus.i_rd_rdy, 1);
    nxt(); bus.i_rd_req = 0; flush = 0; bus.arready = 1;
    nxt(); bus.arready = 0; bus.rvalid = 1; bus.rid = 0; bus.rlast = 1; bus.rdata = 32'h77;
    mid(); chk("fl_after_iv", bus.i_ret_valid, 1); chk("fl_after_data", bus.i_ret_data, 32'h77);
    nxt(); bus.rvalid = 0; bus.rlast = 0;
    // reset mid-burst
    line_req_i(32'h1fc00080);
    bus.rvalid = 1; bus.rid = 0; bus.rlast = 0;
    mid(); chk("rb_beat1_iv", bus.i_ret_valid, 1);
    nxt();
    mid(); chk("rb_beat2_iv", bus.i_ret_valid, 1);
    reset = 1; #1;
    chk("rb_async_iv", bus.i_ret_valid, 0);
    chk("rb_async_axi", {bus.rready, bus.arvalid, bus.arlen, bus.araddr}, 0);
    nxt(); nxt(); reset = 0;
    for (int s = 0; s < 3; s++) begin
      bus.rvalid = 1; bus.rid = 4'(s % 2); bus.rlast = s == 2;
      mid();
      chk($sformatf("rb_stray%0d_v", s), {bus.i_ret_valid, bus.d_ret_valid}, 0);
      chk($sformatf("rb_stray%0d_rready", s), bus.rready, 0);
      nxt();
    end
    bus.rvalid = 0; bus.rlast = 0;
    bus.i_rd_req = 1; bus.d_rd_req = 1;
    mid(); chk("rb_first_d", bus.d_rd_rdy, 1);
    nxt(); bus.i_rd_req = 0; bus.d_rd_req = 0;
    serve(1, 1);
    // random traffic
    for (int c = 0; c < 5000; c++) begin
      bit match;
      bus.i_rd_req = $urandom_range(0, 1) == 1;
      bus.d_rd_req = $urandom_range(0, 1) == 1;
      bus.i_rd_type = $urandom_range(0, 1) == 1 ? 3'b100 : 3'($urandom_range(0, 7));
      bus.d_rd_type = $urandom_range(0, 1) == 1 ? 3'b100 : 3'($urandom_range(0, 7));
      bus.i_rd_addr = $urandom; bus.d_rd_addr = $urandom;
      flush = $urandom_range(0, 9) == 0;
      bus.arready = $urandom_range(0, 1) == 1;
      match = $urandom_range(0, 7) != 0;
      bus.rvalid = $urandom_range(0, 2) != 0;
      bus.rid = match ? {3'd0, m_own_d} : ($urandom_range(0, 3) == 0 ? 4'hf : {3'd0, ~m_own_d});
      bus.rlast = match && (m_long ? $urandom_range(0, 3) == 0 : 1'b1);
      bus.rdata = $urandom;
      reset = $urandom_range(0, 199) == 0;
      nxt();
    end
    reset = 0;
    nxt(); mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
